// File: rtl/instr_encoder_if.sv
// Request and instruction-memory write bundle for instr_encoder.
// The slave modport is the encoder's view; the master modport is the
// view of whoever feeds requests and services the memory writes.
interface instr_encoder_if #(
    parameter int XLEN = 64
);
    logic            req_valid_i;
    logic            req_ready_o;
    logic [10:0]     req_op_i;
    logic [2:0]      req_fun3_i;
    logic [6:0]      req_fun7_i;
    logic [4:0]      req_rd_i;
    logic [4:0]      req_rs1_i;
    logic [4:0]      req_rs2_i;
    logic [XLEN-1:0] req_imme_i;
    logic            imem_we_o;
    logic [XLEN-1:0] imem_addr_o;
    logic [31:0]     imem_wdata_o;
    logic            imem_ready_i;

    modport slave (
        input  req_valid_i, req_op_i, req_fun3_i, req_fun7_i,
        input  req_rd_i, req_rs1_i, req_rs2_i, req_imme_i,
        output req_ready_o,
        output imem_we_o, imem_addr_o, imem_wdata_o,
        input  imem_ready_i
    );

    modport master (
        output req_valid_i, req_op_i, req_fun3_i, req_fun7_i,
        output req_rd_i, req_rs1_i, req_rs2_i, req_imme_i,
        input  req_ready_o,
        input  imem_we_o, imem_addr_o, imem_wdata_o,
        output imem_ready_i
    );
endinterface

// File: rtl/instr_encoder.sv
// RV64I instruction encoder and instruction-memory writer.
// Decoded fields are packed into 32-bit words (one-hot opcode as in decode),
// queued in a small FIFO and written to consecutive memory addresses.
module instr_encoder #(
    parameter int XLEN  = 64,
    parameter int DEPTH = 4
) (
    input  logic            clk_i,
    input  logic            rst_n_i,
    input  logic            start_i,
    input  logic            stop_i,
    input  logic [XLEN-1:0] base_addr_i,
    output logic            done_o,
    output logic            err_o,
    output logic [15:0]     count_o,
    instr_encoder_if.slave  bus
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [AW:0] FULL_CNT_C = (AW+1)'(DEPTH);

    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_ALUR   = 7'b0110011;
    localparam logic [6:0] OPC_ALURW  = 7'b0111011;
    localparam logic [6:0] OPC_ALUI   = 7'b0010011;
    localparam logic [6:0] OPC_ALUIW  = 7'b0011011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    // True when exactly one opcode bit is set.
    function automatic logic is_onehot(input logic [10:0] op);
        return (op != 11'd0) && ((op & (op - 11'd1)) == 11'd0);
    endfunction

    // Pack decoded fields into an instruction word; op is assumed one-hot.
    function automatic logic [31:0] encode(
        input logic [10:0] op,
        input logic [2:0]  f3,
        input logic [6:0]  f7,
        input logic [4:0]  rd,
        input logic [4:0]  rs1,
        input logic [4:0]  rs2,
        input logic [31:0] imm
    );
        logic [31:0] w;
        logic [11:0] i_field;
        w       = 32'd0;
        i_field = imm[11:0];
        case (1'b1)
            op[0]:  w = {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], OPC_BRANCH};
            op[1]:  w = {imm[20], imm[10:1], imm[11], imm[19:12], rd, OPC_JAL};
            op[2]:  w = {imm[11:0], rs1, f3, rd, OPC_JALR};
            op[3]:  w = {imm[11:5], rs2, rs1, f3, imm[4:0], OPC_STORE};
            op[4]:  w = {imm[11:0], rs1, f3, rd, OPC_LOAD};
            op[5]:  w = {f7, rs2, rs1, f3, rd, OPC_ALUR};
            op[6]:  w = {f7, rs2, rs1, f3, rd, OPC_ALURW};
            op[7]: begin
                // 64-bit shifts carry a 6-bit shamt under the upper funct bits
                if ((f3 == 3'b001) || (f3 == 3'b101)) begin
                    i_field = {f7[6:1], imm[5:0]};
                end else begin
                    i_field = imm[11:0];
                end
                w = {i_field, rs1, f3, rd, OPC_ALUI};
            end
            op[8]: begin
                // word shifts carry a 5-bit shamt under a full funct7
                if ((f3 == 3'b001) || (f3 == 3'b101)) begin
                    i_field = {f7, imm[4:0]};
                end else begin
                    i_field = imm[11:0];
                end
                w = {i_field, rs1, f3, rd, OPC_ALUIW};
            end
            op[9]:  w = {imm[31:12], rd, OPC_LUI};
            op[10]: w = {imm[31:12], rd, OPC_AUIPC};
            default: w = 32'd0;
        endcase
        return w;
    endfunction

    state_t          state_r;
    state_t          state_next_s;
    logic [31:0]     mem_r [DEPTH];
    logic [AW-1:0]   wr_ptr_r;
    logic [AW-1:0]   rd_ptr_r;
    logic [AW:0]     cnt_r;
    logic [AW:0]     cnt_next_s;
    logic [XLEN-1:0] addr_r;
    logic [15:0]     count_r;
    logic            err_r;
    logic            done_r;

    logic            fifo_empty_s;
    logic            fifo_full_s;
    logic            req_ready_s;
    logic            accept_s;
    logic            req_bad_s;
    logic            push_s;
    logic            pop_s;
    logic            we_s;
    logic [31:0]     enc_s;

    assign fifo_empty_s = (cnt_r == {(AW+1){1'b0}});
    assign fifo_full_s  = (cnt_r == FULL_CNT_C);
    assign req_ready_s  = (state_r == ST_RUN) && !fifo_full_s;
    assign we_s         = (state_r != ST_IDLE) && !fifo_empty_s;
    assign accept_s     = bus.req_valid_i && req_ready_s;
    // Branch and jal targets must be halfword aligned; the encoding drops imm[0].
    assign req_bad_s    = !is_onehot(bus.req_op_i) ||
                          ((bus.req_op_i[0] || bus.req_op_i[1]) && bus.req_imme_i[0]);
    assign push_s       = accept_s && !req_bad_s;
    assign pop_s        = we_s && bus.imem_ready_i;
    assign enc_s        = encode(bus.req_op_i, bus.req_fun3_i, bus.req_fun7_i,
                                 bus.req_rd_i, bus.req_rs1_i, bus.req_rs2_i,
                                 bus.req_imme_i[31:0]);

    assign bus.req_ready_o  = req_ready_s;
    assign bus.imem_we_o    = we_s;
    assign bus.imem_addr_o  = addr_r;
    assign bus.imem_wdata_o = mem_r[rd_ptr_r];
    assign done_o           = done_r;
    assign err_o            = err_r;
    assign count_o          = count_r;

    // FIFO occupancy after this cycle's push/pop.
    always_comb begin
        cnt_next_s = cnt_r;
        case ({push_s, pop_s})
            2'b10:   cnt_next_s = cnt_r + (AW+1)'(1);
            2'b01:   cnt_next_s = cnt_r - (AW+1)'(1);
            default: cnt_next_s = cnt_r;
        endcase
    end

    // Control FSM next-state: start wins in IDLE, stop drains, empty FIFO finishes.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (start_i) begin
                    state_next_s = ST_RUN;
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (stop_i) begin
                    state_next_s = ST_DRAIN;
                end else begin
                    state_next_s = ST_RUN;
                end
            end
            ST_DRAIN: begin
                if (fifo_empty_s) begin
                    state_next_s = ST_IDLE;
                end else begin
                    state_next_s = ST_DRAIN;
                end
            end
            default: state_next_s = ST_IDLE;
        endcase
    end

    // State register plus done flag, raised for the single DRAIN-and-empty cycle.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_r <= ST_IDLE;
            done_r  <= 1'b0;
        end else begin
            state_r <= state_next_s;
            done_r  <= (state_next_s == ST_DRAIN) && (cnt_next_s == {(AW+1){1'b0}});
        end
    end

    // FIFO storage and pointers; contents are discarded on reset.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= 32'd0;
            end
            wr_ptr_r <= {AW{1'b0}};
            rd_ptr_r <= {AW{1'b0}};
            cnt_r    <= {(AW+1){1'b0}};
        end else begin
            if (push_s) begin
                mem_r[wr_ptr_r] <= enc_s;
                wr_ptr_r        <= wr_ptr_r + AW'(1);
            end else begin
                wr_ptr_r        <= wr_ptr_r;
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + AW'(1);
            end else begin
                rd_ptr_r <= rd_ptr_r;
            end
            cnt_r <= cnt_next_s;
        end
    end

    // Write address and word counter: loaded/cleared on start, advanced per transfer.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            addr_r  <= {XLEN{1'b0}};
            count_r <= 16'd0;
        end else if ((state_r == ST_IDLE) && start_i) begin
            addr_r  <= base_addr_i;
            count_r <= 16'd0;
        end else if (pop_s) begin
            addr_r  <= addr_r + XLEN'(4);
            count_r <= count_r + 16'd1;
        end else begin
            addr_r  <= addr_r;
            count_r <= count_r;
        end
    end

    // Sticky error for malformed accepted requests, cleared by the next start.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            err_r <= 1'b0;
        end else if ((state_r == ST_IDLE) && start_i) begin
            err_r <= 1'b0;
        end else if (accept_s && req_bad_s) begin
            err_r <= 1'b1;
        end else begin
            err_r <= err_r;
        end
    end

endmodule

// File: tb/tb_instr_encoder.sv
// Self-checking bench for instr_encoder: a queue-based reference model
// predicts every memory write, plus handshake, done, err and count.
module tb_instr_encoder;
    localparam int XLEN  = 64;
    localparam int DEPTH = 4;

    logic            clk_i = 1'b0;
    logic            rst_n_i;
    logic            start_i;
    logic            stop_i;
    logic [XLEN-1:0] base_addr_i;
    logic            done_o;
    logic            err_o;
    logic [15:0]     count_o;

    instr_encoder_if #(.XLEN(XLEN)) bus ();

    instr_encoder #(.XLEN(XLEN), .DEPTH(DEPTH)) dut (
        .clk_i       (clk_i),
        .rst_n_i     (rst_n_i),
        .start_i     (start_i),
        .stop_i      (stop_i),
        .base_addr_i (base_addr_i),
        .done_o      (done_o),
        .err_o       (err_o),
        .count_o     (count_o),
        .bus         (bus)
    );

    always #5 clk_i = ~clk_i;

    int n_checks = 0;
    int n_fail   = 0;

    // reference model state
    logic [31:0] m_q[$];
    logic [63:0] m_addr = 64'd0;
    int          m_count = 0;
    logic        m_err = 1'b0;
    int          m_mode = 0;       // 0 idle, 1 run, 2 drain
    bit          m_ready_exp = 1'b0;
    int          ready_mode = 1;   // 0 low, 1 high, 2 random

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] m_enc(input int k, input logic [2:0] f3, input logic [6:0] f7,
                                          input logic [4:0] rd, input logic [4:0] rs1,
                                          input logic [4:0] rs2, input logic [63:0] imm);
        logic [63:0] w;
        logic [63:0] opc;
        logic [63:0] fld;
        case (k)
            0: opc = 64'h63;  1: opc = 64'h6F;  2: opc = 64'h67;  3: opc = 64'h23;
            4: opc = 64'h03;  5: opc = 64'h33;  6: opc = 64'h3B;  7: opc = 64'h13;
            8: opc = 64'h1B;  9: opc = 64'h37;  10: opc = 64'h17;
            default: opc = 64'h0;
        endcase
        w = opc;
        case (k)
            5, 6: w = w + (64'(rd) << 7) + (64'(f3) << 12) + (64'(rs1) << 15)
                        + (64'(rs2) << 20) + (64'(f7) << 25);
            2, 4, 7, 8: begin
                fld = imm & 64'hFFF;
                if (k == 7 && (f3 == 3'd1 || f3 == 3'd5)) fld = ((64'(f7) >> 1) << 6) + (imm & 64'd63);
                if (k == 8 && (f3 == 3'd1 || f3 == 3'd5)) fld = (64'(f7) << 5) + (imm & 64'd31);
                w = w + (64'(rd) << 7) + (64'(f3) << 12) + (64'(rs1) << 15) + (fld << 20);
            end
            3: w = w + ((imm & 64'd31) << 7) + (64'(f3) << 12) + (64'(rs1) << 15)
                     + (64'(rs2) << 20) + (((imm >> 5) & 64'd127) << 25);
            0: w = w + (((imm >> 11) & 64'd1) << 7) + (((imm >> 1) & 64'd15) << 8)
                     + (64'(f3) << 12) + (64'(rs1) << 15) + (64'(rs2) << 20)
                     + (((imm >> 5) & 64'd63) << 25) + (((imm >> 12) & 64'd1) << 31);
            9, 10: w = w + (64'(rd) << 7) + (imm & 64'hFFFFF000);
            1: w = w + (64'(rd) << 7) + (((imm >> 12) & 64'd255) << 12)
                     + (((imm >> 11) & 64'd1) << 20) + (((imm >> 1) & 64'd1023) << 21)
                     + (((imm >> 20) & 64'd1) << 31);
            default: w = 64'd0;
        endcase
        return w[31:0];
    endfunction

    // memory-side responder
    initial begin
        bus.imem_ready_i = 1'b0;
        forever begin
            @(posedge clk_i);
            #1;
            case (ready_mode)
                0:       bus.imem_ready_i = 1'b0;
                1:       bus.imem_ready_i = 1'b1;
                default: bus.imem_ready_i = 1'($urandom_range(0, 1));
            endcase
        end
    end

    // compare process
    always @(negedge clk_i) begin
        if (rst_n_i === 1'b1) begin
            m_ready_exp = (m_mode == 1) && (m_q.size() < DEPTH);
            check("req_ready", 64'(bus.req_ready_o), 64'(m_ready_exp));
            check("imem_we", 64'(bus.imem_we_o), 64'((m_mode != 0) && (m_q.size() != 0)));
            check("done", 64'(done_o), 64'((m_mode == 2) && (m_q.size() == 0)));
            check("err", 64'(err_o), 64'(m_err));
            check("count", 64'(count_o), 64'(m_count[15:0]));
            if (m_mode == 2 && m_q.size() == 0) begin
                m_mode = 0;
            end else if (bus.imem_we_o === 1'b1 && m_q.size() != 0) begin
                check("wdata", 64'(bus.imem_wdata_o), 64'(m_q[0]));
                check("waddr", bus.imem_addr_o, m_addr);
                if (bus.imem_ready_i) begin
                    void'(m_q.pop_front());
                    m_addr  = m_addr + 64'd4;
                    m_count = m_count + 1;
                end
            end
        end else begin
            m_ready_exp = 1'b0;
        end
    end

    task automatic do_start(input logic [63:0] base);
        base_addr_i = base;
        start_i = 1'b1;
        @(posedge clk_i);
        if (m_mode == 0) begin
            m_mode = 1; m_addr = base; m_count = 0; m_err = 1'b0;
        end
        #1 start_i = 1'b0;
    endtask

    task automatic do_stop();
        stop_i = 1'b1;
        @(posedge clk_i);
        if (m_mode == 1) m_mode = 2;
        #1 stop_i = 1'b0;
    endtask

    task automatic send(input logic [10:0] op, input logic [2:0] f3, input logic [6:0] f7,
                        input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2,
                        input logic [63:0] imm, input bit with_stop);
        bit acc = 1'b0;
        int t = 0;
        int k = 0;
        bus.req_op_i = op; bus.req_fun3_i = f3; bus.req_fun7_i = f7;
        bus.req_rd_i = rd; bus.req_rs1_i = rs1; bus.req_rs2_i = rs2; bus.req_imme_i = imm;
        bus.req_valid_i = 1'b1;
        while (!acc && t < 200) begin
            @(negedge clk_i);
            #1;
            if (with_stop && m_ready_exp) stop_i = 1'b1;
            @(posedge clk_i);
            if (m_ready_exp) begin
                acc = 1'b1;
                if ($countones(op) != 1 || ((op[0] || op[1]) && imm[0])) begin
                    m_err = 1'b1;
                end else begin
                    for (int i = 0; i < 11; i++) if (op[i]) k = i;
                    m_q.push_back(m_enc(k, f3, f7, rd, rs1, rs2, imm));
                end
            end
            if (stop_i && m_mode == 1) m_mode = 2;
            #1 stop_i = 1'b0;
            t++;
        end
        bus.req_valid_i = 1'b0;
        check("accept_timeout", 64'(acc), 64'd1);
    endtask

    task automatic send_rand(input bit with_stop);
        int sel;
        logic [10:0] op;
        logic [63:0] imm;
        sel = $urandom_range(0, 15);
        if (sel < 11) op = 11'd1 << sel;
        else if (sel < 14) op = 11'($urandom);
        else op = 11'd0;
        imm = {$urandom, $urandom};
        send(op, 3'($urandom), 7'($urandom), 5'($urandom), 5'($urandom), 5'($urandom), imm, with_stop);
    endtask

    task automatic wait_idle();
        int t = 0;
        while (m_mode != 0 && t < 300) begin
            @(posedge clk_i);
            t++;
        end
        check("drain_timeout", 64'(m_mode == 0), 64'd1);
        @(posedge clk_i);
        #1;
    endtask

    initial begin
        int n;
        rst_n_i = 1'b0; start_i = 1'b0; stop_i = 1'b0; base_addr_i = 64'd0;
        bus.req_valid_i = 1'b0; bus.req_op_i = 11'd0; bus.req_fun3_i = 3'd0; bus.req_fun7_i = 7'd0;
        bus.req_rd_i = 5'd0; bus.req_rs1_i = 5'd0; bus.req_rs2_i = 5'd0; bus.req_imme_i = 64'd0;
        repeat (2) @(posedge clk_i);
        #2;
        check("rst_we", 64'(bus.imem_we_o), 64'd0);
        check("rst_ready", 64'(bus.req_ready_o), 64'd0);
        check("rst_done", 64'(done_o), 64'd0);
        check("rst_err", 64'(err_o), 64'd0);
        check("rst_count", 64'(count_o), 64'd0);
        check("rst_addr", bus.imem_addr_o, 64'd0);
        check("rst_wdata", 64'(bus.imem_wdata_o), 64'd0);
        rst_n_i = 1'b1;
        @(posedge clk_i);
        #1;

        // pin the model with hand-encoded words
        check("pin_addi", 64'(m_enc(7, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 64'd5)), 64'h00500093);
        check("pin_add",  64'(m_enc(5, 3'd0, 7'd0, 5'd3, 5'd1, 5'd2, 64'd0)), 64'h002081B3);
        check("pin_sub",  64'(m_enc(5, 3'd0, 7'h20, 5'd3, 5'd1, 5'd2, 64'd0)), 64'h402081B3);
        check("pin_sw",   64'(m_enc(3, 3'd2, 7'd0, 5'd0, 5'd1, 5'd2, 64'd8)), 64'h0020A423);
        check("pin_beq",  64'(m_enc(0, 3'd0, 7'd0, 5'd0, 5'd0, 5'd0, 64'd8)), 64'h00000463);
        check("pin_jal",  64'(m_enc(1, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 64'd16)), 64'h010000EF);
        check("pin_lui",  64'(m_enc(9, 3'd0, 7'd0, 5'd5, 5'd0, 5'd0, 64'h12345000)), 64'h123452B7);
        check("pin_srai", 64'(m_enc(7, 3'd5, 7'h20, 5'd1, 5'd1, 5'd0, 64'd3)), 64'h4030D093);

        // program
        ready_mode = 1;
        do_start(64'h1000);
        send(11'h080, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 64'd5, 1'b0);
        send(11'h020, 3'd0, 7'd0, 5'd3, 5'd1, 5'd2, 64'd0, 1'b0);
        send(11'h020, 3'd0, 7'h20, 5'd3, 5'd1, 5'd2, 64'd0, 1'b0);
        do_stop();
        wait_idle();
        check("prog_count", 64'(count_o), 64'd3);

        // formats
        do_start(64'h2000);
        send(11'h008, 3'd2, 7'd0, 5'd0, 5'd1, 5'd2, 64'd8, 1'b0);
        send(11'h001, 3'd0, 7'd0, 5'd0, 5'd0, 5'd0, 64'd8, 1'b0);
        send(11'h002, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 64'd16, 1'b0);
        send(11'h200, 3'd0, 7'd0, 5'd5, 5'd0, 5'd0, 64'h12345000, 1'b0);
        send(11'h080, 3'd5, 7'h20, 5'd1, 5'd1, 5'd0, 64'd3, 1'b0);
        do_stop();
        wait_idle();

        // backpressure
        ready_mode = 0;
        do_start(64'h3000);
        for (int i = 0; i < 4; i++) send(11'h020, 3'(i), 7'd0, 5'(i), 5'd1, 5'd2, 64'd0, 1'b0);
        check("bp_full_ready", 64'(bus.req_ready_o), 64'd0);
        repeat (3) @(posedge clk_i);
        #1;
        check("bp_stall_addr", bus.imem_addr_o, 64'h3000);
        ready_mode = 1;
        send(11'h400, 3'd0, 7'd0, 5'd7, 5'd0, 5'd0, 64'hABCDE000, 1'b0);
        send(11'h010, 3'd3, 7'd0, 5'd8, 5'd9, 5'd0, 64'hFFFF_FFFF_FFFF_FFF0, 1'b0);
        do_stop();
        wait_idle();
        check("bp_count", 64'(count_o), 64'd6);

        // errors
        do_start(64'h4000);
        send(11'h000, 3'd0, 7'd0, 5'd1, 5'd1, 5'd1, 64'd4, 1'b0);
        send(11'h030, 3'd0, 7'd0, 5'd1, 5'd1, 5'd1, 64'd4, 1'b0);
        send(11'h002, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 64'd3, 1'b0);
        send(11'h020, 3'd0, 7'd0, 5'd3, 5'd1, 5'd2, 64'd0, 1'b0);
        do_stop();
        wait_idle();
        check("err_sticky", 64'(err_o), 64'd1);
        check("err_count", 64'(count_o), 64'd1);
        do_start(64'h4100);
        #2;
        check("err_cleared", 64'(err_o), 64'd0);
        do_stop();
        wait_idle();

        // control corners
        do_start(64'h5000);
        send(11'h020, 3'd0, 7'd0, 5'd3, 5'd1, 5'd2, 64'd0, 1'b0);
        do_start(64'h9000);
        send(11'h040, 3'd0, 7'd1, 5'd4, 5'd5, 5'd6, 64'd0, 1'b0);
        send(11'h100, 3'd1, 7'd0, 5'd4, 5'd4, 5'd0, 64'd7, 1'b1);
        wait_idle();
        check("corner_count", 64'(count_o), 64'd3);
        do_stop();
        repeat (3) @(posedge clk_i);
        #1;
        check("stop_idle_ready", 64'(bus.req_ready_o), 64'd0);

        // randomized rounds
        for (int r = 0; r < 5; r++) begin
            ready_mode = 2;
            if (r == 0) do_start(64'hFFFF_FFFF_FFFF_FFF8);
            else do_start({$urandom, $urandom});
            for (int i = 0; i < 15; i++) begin
                n = $urandom_range(0, 2);
                repeat (n) begin @(posedge clk_i); #1; end
                send_rand((i == 14) && r[0]);
            end
            if (!r[0]) do_stop();
            wait_idle();
        end

        // reset with queued words
        ready_mode = 0;
        do_start(64'h6000);
        send(11'h020, 3'd0, 7'd0, 5'd1, 5'd2, 5'd3, 64'd0, 1'b0);
        send(11'h020, 3'd1, 7'd0, 5'd1, 5'd2, 5'd3, 64'd0, 1'b0);
        send(11'h020, 3'd2, 7'd0, 5'd1, 5'd2, 5'd3, 64'd0, 1'b0);
        #2;
        check("pre_rst_we", 64'(bus.imem_we_o), 64'd1);
        rst_n_i = 1'b0;
        m_q.delete(); m_mode = 0; m_count = 0; m_addr = 64'd0; m_err = 1'b0;
        #1;
        check("rst_async_we", 64'(bus.imem_we_o), 64'd0);
        check("rst_async_addr", bus.imem_addr_o, 64'd0);
        repeat (2) @(posedge clk_i);
        #1;
        rst_n_i = 1'b1;
        ready_mode = 1;
        repeat (5) @(posedge clk_i);
        #1;
        check("post_rst_count", 64'(count_o), 64'd0);
        check("post_rst_ready", 64'(bus.req_ready_o), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
